// File: rtl/lc3b_types.sv
// lc3b_types: shared word type and arbiter state encoding
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE,
        IF_ACT,
        MEM_ACT,
        DONE
    } lc3b_arb_state;

endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: counts back-to-back MEM grants made while IF waits, saturating at the limit
module arb_starve_counter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_grant,
    input  logic if_grant,
    input  logic if_pending,
    output logic starve
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] streak;

    // streak grows only while IF is kept waiting; any IF grant or uncontended MEM grant clears it
    always_ff @(posedge clk) begin
        if (rst || if_grant || (mem_grant && !if_pending))
            streak <= '0;
        else if (mem_grant && !starve)
            streak <= streak + 1'b1;
    end

    assign starve = streak == SW'(STARVE_LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises IF and MEM client requests onto one physical memory port
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  lc3b_word    if_memaddr,
    input  logic [1:0]  if_mem_byte_enable,
    input  logic        if_memread,
    output logic        if_mem_resp,
    output lc3b_word    if_mem_rdata,
    input  lc3b_word    mem_memaddr,
    input  logic [1:0]  mem_mem_byte_enable,
    input  logic        mem_memread,
    input  logic        mem_memwrite,
    input  lc3b_word    mem_mem_wdata,
    output logic        mem_mem_resp,
    output lc3b_word    mem_mem_rdata,
    output lc3b_word    pmem_address,
    output logic [1:0]  pmem_byte_enable,
    output logic        pmem_read,
    output logic        pmem_write,
    output lc3b_word    pmem_wdata,
    input  lc3b_word    pmem_rdata,
    input  logic        pmem_resp
);

    lc3b_arb_state state, next_state;
    lc3b_word      rdata_q;
    logic          gnt_if;
    logic          mem_grant, if_grant, starve;

    // grant decision is only made in IDLE; MEM wins unless IF has been starved
    always_comb begin
        mem_grant  = (state == IDLE) && (mem_memread || mem_memwrite) && (!if_memread || !starve);
        if_grant   = (state == IDLE) && if_memread && !mem_grant;
        next_state = (state == IDLE) ? (mem_grant ? MEM_ACT : if_grant ? IF_ACT : IDLE) :
                     (state == DONE) ? IDLE :
                     pmem_resp       ? DONE : state;
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // latch the granted request onto pmem_*, then capture read data on completion
    always_ff @(posedge clk) begin
        if (rst) begin
            pmem_address     <= '0;
            pmem_byte_enable <= '0;
            pmem_wdata       <= '0;
            pmem_read        <= 1'b0;
            pmem_write       <= 1'b0;
            rdata_q          <= '0;
            gnt_if           <= 1'b0;
        end else if (mem_grant) begin
            pmem_address     <= mem_memaddr;
            pmem_byte_enable <= mem_mem_byte_enable;
            pmem_wdata       <= mem_memwrite ? mem_mem_wdata : '0;
            pmem_write       <= mem_memwrite;
            pmem_read        <= !mem_memwrite;
            gnt_if           <= 1'b0;
        end else if (if_grant) begin
            pmem_address     <= if_memaddr;
            pmem_byte_enable <= if_mem_byte_enable;
            pmem_wdata       <= '0;
            pmem_write       <= 1'b0;
            pmem_read        <= 1'b1;
            gnt_if           <= 1'b1;
        end else if ((state == IF_ACT || state == MEM_ACT) && pmem_resp) begin
            rdata_q          <= pmem_write ? '0 : pmem_rdata;
            pmem_read        <= 1'b0;
            pmem_write       <= 1'b0;
        end
    end

    assign if_mem_resp   = (state == DONE) && gnt_if;
    assign mem_mem_resp  = (state == DONE) && !gnt_if;
    assign if_mem_rdata  = if_mem_resp ? rdata_q : '0;
    assign mem_mem_rdata = mem_mem_resp ? rdata_q : '0;

    arb_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .clk        (clk),
        .rst        (rst),
        .mem_grant  (mem_grant),
        .if_grant   (if_grant),
        .if_pending (if_memread),
        .starve     (starve)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter with a behavioural physical memory
module tb_mem_arbiter;
    import lc3b_types::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    lc3b_word   if_memaddr = '0;
    logic [1:0] if_mem_byte_enable = '0;
    logic       if_memread = 1'b0;
    logic       if_mem_resp;
    lc3b_word   if_mem_rdata;
    lc3b_word   mem_memaddr = '0;
    logic [1:0] mem_mem_byte_enable = '0;
    logic       mem_memread = 1'b0;
    logic       mem_memwrite = 1'b0;
    lc3b_word   mem_mem_wdata = '0;
    logic       mem_mem_resp;
    lc3b_word   mem_mem_rdata;
    lc3b_word   pmem_address;
    logic [1:0] pmem_byte_enable;
    logic       pmem_read;
    logic       pmem_write;
    lc3b_word   pmem_wdata;
    lc3b_word   pmem_rdata = '0;
    logic       pmem_resp = 1'b0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .if_memaddr          (if_memaddr),
        .if_mem_byte_enable  (if_mem_byte_enable),
        .if_memread          (if_memread),
        .if_mem_resp         (if_mem_resp),
        .if_mem_rdata        (if_mem_rdata),
        .mem_memaddr         (mem_memaddr),
        .mem_mem_byte_enable (mem_mem_byte_enable),
        .mem_memread         (mem_memread),
        .mem_memwrite        (mem_memwrite),
        .mem_mem_wdata       (mem_mem_wdata),
        .mem_mem_resp        (mem_mem_resp),
        .mem_mem_rdata       (mem_mem_rdata),
        .pmem_address        (pmem_address),
        .pmem_byte_enable    (pmem_byte_enable),
        .pmem_read           (pmem_read),
        .pmem_write          (pmem_write),
        .pmem_wdata          (pmem_wdata),
        .pmem_rdata          (pmem_rdata),
        .pmem_resp           (pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic     is_if;
        lc3b_word data;
    } exp_t;

    exp_t     sb[$];
    lc3b_word mem_model[lc3b_word];
    int       n_tests = 0;
    int       n_fail  = 0;
    int       viol    = 0;

    // protocol checker: a simultaneous read and write from MEM is illegal stimulus
    always @(posedge clk) begin
        if (!rst && mem_memread && mem_memwrite) begin
            if (viol == 0)
                $display("[TB] protocol violation: mem_memread and mem_memwrite both high at %0t", $time);
            viol++;
        end
    end

    function automatic lc3b_word model_rd(input lc3b_word a);
        return mem_model.exists(a) ? mem_model[a] : (a ^ 16'h5A5A);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic is_if, input lc3b_word data);
        exp_t e;
        e.is_if = is_if;
        e.data  = data;
        sb.push_back(e);
    endtask

    // wait for a physical strobe, hold it for 'delay' cycles, complete it, then score the client resp
    task automatic serve(input string tag, input int delay, input lc3b_word exp_addr,
                         input logic exp_wr, input logic [1:0] exp_be, input lc3b_word exp_wd,
                         input logic chg);
        int       w;
        lc3b_word a;
        exp_t     e;
        w = 0;
        while (!(pmem_read || pmem_write) && w < 20) begin
            tick();
            w++;
        end
        chk({tag, " strobe"}, {pmem_read, pmem_write}, exp_wr ? 2'b01 : 2'b10);
        chk({tag, " addr"}, pmem_address, exp_addr);
        chk({tag, " be/wdata"}, {pmem_byte_enable, exp_wr ? pmem_wdata : 16'h0}, {exp_be, exp_wd});
        a = pmem_address;
        if (chg)
            if_memaddr = 16'h0080;
        for (int i = 1; i < delay; i++)
            tick();
        chk({tag, " held"}, {pmem_read, pmem_write, pmem_address}, {!exp_wr, exp_wr, exp_addr});
        if (pmem_write) begin
            mem_model[a] = pmem_wdata;
            pmem_rdata = 16'hDEAD;
        end else begin
            pmem_rdata = model_rd(a);
        end
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk({tag, " strobe drop"}, {pmem_read, pmem_write}, 2'b00);
        if (sb.size() == 0) begin
            chk({tag, " scoreboard empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({tag, " resp"}, {if_mem_resp, mem_mem_resp}, e.is_if ? 2'b10 : 2'b01);
            chk({tag, " rdata"}, e.is_if ? if_mem_rdata : mem_mem_rdata, e.data);
        end
        if (if_mem_resp)
            if_memread = 1'b0;
        if (mem_mem_resp) begin
            mem_memread  = 1'b0;
            mem_memwrite = 1'b0;
        end
    endtask

    initial begin
        mem_model[16'h0040] = 16'h1234;
        tick();
        tick();
        chk("reset outputs",
            {if_mem_resp, if_mem_rdata, mem_mem_resp, mem_mem_rdata, pmem_address,
             pmem_byte_enable, pmem_read, pmem_write, pmem_wdata}, 0);
        rst = 1'b0;
        tick();

        // 1: lone IF read, three-cycle physical access
        if_memaddr = 16'h0040;
        if_mem_byte_enable = 2'b11;
        if_memread = 1'b1;
        push(1'b1, model_rd(16'h0040));
        tick();
        chk("t1 latency", pmem_read, 1'b1);
        serve("t1", 3, 16'h0040, 1'b0, 2'b11, 16'h0, 1'b0);
        tick();
        chk("t1 single pulse", {if_mem_resp, pmem_read}, 2'b00);

        // 2: simultaneous IF read and MEM write; MEM first
        if_memread = 1'b1;
        mem_memaddr = 16'h0100;
        mem_mem_wdata = 16'hBEEF;
        mem_mem_byte_enable = 2'b01;
        mem_memwrite = 1'b1;
        push(1'b0, 16'h0000);
        push(1'b1, model_rd(16'h0040));
        serve("t2 mem", 1, 16'h0100, 1'b1, 2'b01, 16'hBEEF, 1'b0);
        tick();
        chk("t2 idle gap", {pmem_read, pmem_write}, 2'b00);
        serve("t2 if", 2, 16'h0040, 1'b0, 2'b11, 16'h0, 1'b0);
        tick();

        // 3: starvation; four MEM grants, then IF, then MEM again
        if_memread = 1'b1;
        mem_mem_byte_enable = 2'b11;
        mem_memaddr = 16'h0110;
        mem_mem_wdata = 16'h0A00;
        mem_memwrite = 1'b1;
        for (int k = 0; k < 4; k++)
            push(1'b0, 16'h0000);
        push(1'b1, model_rd(16'h0040));
        push(1'b0, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            serve("t3 mem", 1, 16'h0110 + 16'(k), 1'b1, 2'b11, 16'h0A00 + 16'(k), 1'b0);
            mem_memaddr = 16'h0111 + 16'(k);
            mem_mem_wdata = 16'h0A01 + 16'(k);
            mem_memwrite = 1'b1;
            tick();
        end
        chk("t3 streak saturated", dut.u_starve.streak, 4);
        serve("t3 if forced", 1, 16'h0040, 1'b0, 2'b11, 16'h0, 1'b0);
        chk("t3 streak cleared", dut.u_starve.streak, 0);
        tick();
        serve("t3 mem after", 1, 16'h0114, 1'b1, 2'b11, 16'h0A04, 1'b0);
        chk("t3 streak idle", dut.u_starve.streak, 0);
        tick();

        // 4: IF address changes mid-transaction
        if_memaddr = 16'h0040;
        if_memread = 1'b1;
        push(1'b1, model_rd(16'h0040));
        serve("t4", 3, 16'h0040, 1'b0, 2'b11, 16'h0, 1'b1);
        tick();

        // 5: reset during MEM_ACT; late pmem_resp ignored
        mem_memaddr = 16'h0300;
        mem_memread = 1'b1;
        tick();
        chk("t5 strobe", pmem_read, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_memread = 1'b0;
        chk("t5 outputs cleared",
            {if_mem_resp, if_mem_rdata, mem_mem_resp, mem_mem_rdata, pmem_address,
             pmem_byte_enable, pmem_read, pmem_write, pmem_wdata}, 0);
        pmem_rdata = 16'h7777;
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk("t5 late resp ignored", {if_mem_resp, mem_mem_resp, pmem_read, pmem_write}, 0);
        tick();
        chk("t5 still idle", {if_mem_resp, mem_mem_resp}, 0);
        mem_memread = 1'b1;
        push(1'b0, model_rd(16'h0300));
        serve("t5 clean", 2, 16'h0300, 1'b0, 2'b11, 16'h0, 1'b0);
        tick();

        // 6: read and write both high; write wins, one resp
        mem_memaddr = 16'h0200;
        mem_mem_wdata = 16'h1111;
        mem_mem_byte_enable = 2'b10;
        mem_memread = 1'b1;
        mem_memwrite = 1'b1;
        push(1'b0, 16'h0000);
        serve("t6", 2, 16'h0200, 1'b1, 2'b10, 16'h1111, 1'b0);
        tick();
        chk("t6 single resp", {mem_mem_resp, pmem_read, pmem_write}, 0);
        chk("t6 violation flagged", viol > 0, 1'b1);
        chk("scoreboard drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
